fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences instruction fetch between the PC datapath and instruction memory.
- Issues word requests over a valid/ready handshake with at most one outstanding request.
- Buffers returned words in a small in-order FIFO toward decode.
- Handles stall back-pressure and jump/branch redirects, discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0, fetch address issued first after reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of two, ≥2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- io_redirect_valid  in  1  jump/branch taken this cycle
- io_redirect_target  in  32  new fetch address (rs1+imm or pc+imm from execute)
- io_stall_en  in  1  decode cannot accept; holds FIFO head
- io_imem_req_valid  out  1  fetch request valid
- io_imem_req_ready  in  1  memory accepts request
- io_imem_req_addr  out  32  fetch address
- io_imem_resp_valid  in  1  response word valid (in order, ≥1 cycle after accept)
- io_imem_resp_data  in  32  instruction word
- io_inst_valid  out  1  FIFO head valid
- io_inst  out  32  FIFO head instruction
- io_inst_pc  out  32  FIFO head PC

Behaviour:
- Reset (reset==0 at posedge):
  - fpc<=RESET_PC, state<=RUN, FIFO emptied.
  - All outputs 0 except io_imem_req_addr==RESET_PC.
  - Reset mid-operation discards FIFO and tracking; any later response arriving in RUN is ignored.
- State RUN:
  - io_imem_req_valid = (count < FIFO_DEPTH) && !io_redirect_valid.
  - Accept (valid&&ready): fpc<=fpc+4 (wraps modulo 2^32), latch req addr as resp_pc, go WAIT.
- State WAIT:
  - req_valid=0.
  - On resp_valid: push {resp_data, resp_pc}, go RUN; a new request may issue the following cycle.
- State DRAIN:
  - req_valid=0.
  - On resp_valid: discard the word, go RUN.
- Redirect (io_redirect_valid=1), any state:
  - fpc<={target[31:2],2'b00}.
  - FIFO flushed; io_inst_valid forced 0 this cycle.
  - RUN stays RUN; no request is issued this cycle, and an unaccepted request may be withdrawn.
  - WAIT with no resp this cycle -> DRAIN.
  - WAIT with resp this cycle -> word dropped, RUN.
  - DRAIN stays DRAIN (its own resp is dropped if it coincides, then RUN).
- Request stability: while req_valid=1 and ready=0 with no redirect, addr holds.
- FIFO:
  - Pop when io_inst_valid && !io_stall_en.
  - Space is reserved at issue (count + outstanding ≤ FIFO_DEPTH), so a push never overflows.
  - Push and pop in the same cycle are allowed; count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Outputs: io_inst/io_inst_pc are the FIFO head registers; undefined contents permitted when io_inst_valid=0 (bench checks only when valid).
- resp_valid outside WAIT/DRAIN is ignored.
- Latency: request accepted at cycle N, response at N+k -> io_inst_valid at N+k+1.
- Sustained throughput with ready=1, 1-cycle response: one instruction per 2 cycles.

Test Plan:
- Reset release, ready=1, 1-cycle memory returning addr as data -> requests 0x0,0x4,0x8…; io_inst/io_inst_pc pairs 0x0/0x0, 0x4/0x4 in order.
- Hold io_stall_en=1 for 10 cycles -> exactly 2 words buffered, req_valid drops; on release, pops 0x0 then 0x4, fetch resumes at 0x8.
- io_imem_req_ready=0 for 5 cycles at addr 0x8 -> req_valid and addr=0x8 held steady; no FIFO change.
- Redirect to 0x103 while in WAIT (no coincident resp) -> FIFO empty next cycle, DRAIN; late response discarded; next request addr 0x100; first io_inst_pc=0x100.
- Redirect coincident with resp_valid in WAIT -> word not pushed, RUN; next request 0x200 for target 0x200.
- reset=0 for one cycle while 1 word buffered and 1 outstanding -> io_inst_valid=0, request addr RESET_PC; stray response ignored.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding imem request, small in-order
// instruction buffer toward decode, stall back-pressure and redirect flushing.
//
// state  | meaning
// S_RUN  | idle/issuing; a request may be presented when the buffer has room
// S_WAIT | one request accepted, response will be buffered
// S_DRAIN| request outstanding but made stale by a redirect; response dropped
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_target,
  input  logic        io_stall_en,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [31:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_inst_valid,
  output logic [31:0] io_inst,
  output logic [31:0] io_inst_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_DRAIN} state_t;

  state_t           r_state;
  logic [31:0]      r_fpc;
  logic [31:0]      r_resp_pc;
  logic [31:0]      r_buf_inst [FIFO_DEPTH];
  logic [31:0]      r_buf_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic        w_req_valid;
  logic        w_accept;
  logic        w_push;
  logic        w_inst_valid;
  logic        w_pop;
  logic [31:0] w_target;
  logic        w_unused;

  // Only S_RUN issues, so count < depth is the same as count + outstanding <= depth.
  assign w_req_valid  = reset && (r_state == S_RUN) && !io_redirect_valid &&
                        (r_count < CNT_W'(FIFO_DEPTH));
  assign w_accept     = w_req_valid && io_imem_req_ready;
  assign w_push       = reset && (r_state == S_WAIT) && io_imem_resp_valid && !io_redirect_valid;
  assign w_inst_valid = reset && (r_count != '0) && !io_redirect_valid;
  assign w_pop        = w_inst_valid && !io_stall_en;
  assign w_target     = {io_redirect_target[31:2], 2'b00};
  assign w_unused     = ^io_redirect_target[1:0];

  assign io_imem_req_valid = w_req_valid;
  assign io_imem_req_addr  = r_fpc;
  assign io_inst_valid     = w_inst_valid;
  assign io_inst           = r_buf_inst[r_rd_ptr];
  assign io_inst_pc        = r_buf_pc[r_rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_RUN;
      r_fpc     <= RESET_PC;
      r_resp_pc <= '0;
    end else if (io_redirect_valid) begin
      r_fpc <= w_target;
      case (r_state)
        S_WAIT, S_DRAIN: r_state <= io_imem_resp_valid ? S_RUN : S_DRAIN;
        default:         r_state <= S_RUN;
      endcase
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_accept) begin
            r_fpc     <= r_fpc + 32'd4;
            r_resp_pc <= r_fpc;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT, S_DRAIN: begin
          if (io_imem_resp_valid) r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_buf_inst[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else if (io_redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf_inst[r_wr_ptr] <= io_imem_resp_data;
        r_buf_pc[r_wr_ptr]   <= r_resp_pc;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then randomized traffic, checked
// against an in-order queue model of the buffered fetch stream.
module tb_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          DEPTH    = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_target;
  logic        io_stall_en;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [31:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_inst_valid;
  logic [31:0] io_inst;
  logic [31:0] io_inst_pc;

  fetch_ctrl #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .io_redirect_valid(io_redirect_valid), .io_redirect_target(io_redirect_target),
    .io_stall_en(io_stall_en),
    .io_imem_req_valid(io_imem_req_valid), .io_imem_req_ready(io_imem_req_ready),
    .io_imem_req_addr(io_imem_req_addr),
    .io_imem_resp_valid(io_imem_resp_valid), .io_imem_resp_data(io_imem_resp_data),
    .io_inst_valid(io_inst_valid), .io_inst(io_inst), .io_inst_pc(io_inst_pc)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // reference model: expected buffer contents (as fetch PCs), next request address,
  // and the single response the memory owes
  logic [31:0] exp_q[$];
  logic [31:0] ref_req;
  bit          pend, pend_stale, pend_orphan;
  logic [31:0] pend_addr;
  int          pend_wait;
  int          mem_k;
  bit          ready_want;
  bit          stray_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock: called at a negedge with redirect/stall/reset/ready_want already set
  task automatic cycle();
    bit resp, stray, rv_exp, iv_exp, eff_ready;
    resp  = 1'b0;
    stray = 1'b0;
    if (pend) begin
      if (pend_wait <= 1) resp = 1'b1;
      else pend_wait--;
    end else if (stray_en && $urandom_range(0, 7) == 0) begin
      stray = 1'b1;
    end
    io_imem_resp_valid = resp || stray;
    io_imem_resp_data  = resp ? mem_word(pend_addr) : $urandom();
    eff_ready = ready_want && !(pend && pend_orphan && !resp);
    io_imem_req_ready  = eff_ready;
    #1;
    iv_exp = reset && (exp_q.size() != 0) && !io_redirect_valid;
    rv_exp = reset && !io_redirect_valid && !(pend && !pend_orphan) && (exp_q.size() < DEPTH);
    chk("req_valid", 32'(io_imem_req_valid), 32'(rv_exp));
    chk("inst_valid", 32'(io_inst_valid), 32'(iv_exp));
    if (io_imem_req_valid) chk("req_addr", io_imem_req_addr, ref_req);
    if (iv_exp && io_inst_valid) begin
      chk("inst_pc", io_inst_pc, exp_q[0]);
      chk("inst", io_inst, mem_word(exp_q[0]));
    end
    if (!reset) begin
      exp_q.delete();
      ref_req = RESET_PC;
      if (resp) pend = 1'b0;
      else if (pend) pend_orphan = 1'b1;
    end else begin
      if (iv_exp && !io_stall_en) void'(exp_q.pop_front());
      if (resp) begin
        if (!pend_stale && !pend_orphan && !io_redirect_valid) exp_q.push_back(pend_addr);
        pend = 1'b0;
      end
      if (io_redirect_valid) begin
        exp_q.delete();
        ref_req = {io_redirect_target[31:2], 2'b00};
        if (pend) pend_stale = 1'b1;
      end else if (rv_exp && eff_ready) begin
        pend        = 1'b1;
        pend_addr   = ref_req;
        pend_wait   = mem_k;
        pend_stale  = 1'b0;
        pend_orphan = 1'b0;
        ref_req     = ref_req + 32'd4;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int n;
    reset = 1'b0; io_redirect_valid = 1'b0; io_redirect_target = '0; io_stall_en = 1'b0;
    io_imem_req_ready = 1'b0; io_imem_resp_valid = 1'b0; io_imem_resp_data = '0;
    exp_q.delete(); ref_req = RESET_PC; pend = 0; pend_stale = 0; pend_orphan = 0;
    pend_addr = '0; pend_wait = 0; mem_k = 1; ready_want = 1'b1; stray_en = 1'b0;
    @(negedge clock);
    run(2);
    reset = 1'b1;
    chk("post_reset_addr", io_imem_req_addr, RESET_PC);

    // stall: buffer fills to depth, requests stop, then drains in order
    io_stall_en = 1'b1;
    run(10);
    chk("stall_head_pc", io_inst_pc, RESET_PC);
    chk("stall_full", 32'(exp_q.size()), 32'(DEPTH));
    io_stall_en = 1'b0;
    run(6);

    // memory back-pressure
    ready_want = 1'b0;
    run(5);
    ready_want = 1'b1;
    run(4);

    // redirect while waiting with no coincident response
    mem_k = 3;
    n = 0;
    while (!(pend && pend_wait > 1) && n < 20) begin cycle(); n++; end
    chk("reach_wait_a", 32'(n < 20), 32'd1);
    io_redirect_valid = 1'b1; io_redirect_target = 32'h103;
    cycle();
    io_redirect_valid = 1'b0;
    chk("drain_addr", io_imem_req_addr, 32'h100);
    run(10);

    // redirect coincident with the response
    mem_k = 2;
    n = 0;
    while (!(pend && pend_wait <= 1 && !pend_stale) && n < 20) begin cycle(); n++; end
    chk("reach_wait_b", 32'(n < 20), 32'd1);
    io_redirect_valid = 1'b1; io_redirect_target = 32'h200;
    cycle();
    io_redirect_valid = 1'b0;
    chk("coinc_addr", io_imem_req_addr, 32'h200);
    run(8);

    // reset with one word buffered and one request outstanding
    mem_k = 3; io_stall_en = 1'b1;
    n = 0;
    while (!(exp_q.size() == 1 && pend && pend_wait > 1) && n < 30) begin cycle(); n++; end
    chk("reach_mid", 32'(n < 30), 32'd1);
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("mid_reset_valid", 32'(io_inst_valid), 32'd0);
    chk("mid_reset_addr", io_imem_req_addr, RESET_PC);
    io_stall_en = 1'b0;
    run(10);

    // randomized traffic
    stray_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      mem_k             = $urandom_range(1, 3);
      ready_want        = ($urandom_range(0, 3) != 0);
      io_stall_en       = ($urandom_range(0, 2) == 0);
      io_redirect_valid = ($urandom_range(0, 15) == 0);
      io_redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom();
      reset             = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1'b1; io_redirect_valid = 1'b0; io_stall_en = 1'b0;
    run(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
